// File: rtl/rx_run_sequencer_pkg.sv
// rtl/rx_run_sequencer_pkg.sv - shared states, status codes, register map and command record for rx_run_sequencer
package rx_run_sequencer_pkg;

    // Widest sample-count field the control word can carry (bit 28 is reserved)
    localparam int NL_W = 28;

    localparam logic [7:0] OFS_CTRL    = 8'd0;
    localparam logic [7:0] OFS_TIME_HI = 8'd1;
    localparam logic [7:0] OFS_TIME_LO = 8'd2;
    localparam logic [7:0] OFS_CLEAR   = 8'd3;

    localparam int BIT_NOW   = 31;
    localparam int BIT_CHAIN = 30;
    localparam int BIT_STOP  = 29;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TIME = 2'd1,
        ST_RUNNING   = 2'd2,
        ST_ERR_HALT  = 2'd3
    } seq_state_t;

    typedef enum logic [2:0] {
        STAT_NONE    = 3'd0,
        STAT_DONE    = 3'd1,
        STAT_LATE    = 3'd2,
        STAT_OVERRUN = 3'd3,
        STAT_BUSY    = 3'd4
    } seq_status_t;

    // Stop commands act immediately and are never queued, so they carry no stop flag here
    typedef struct packed {
        logic            now;
        logic            chain;
        logic [NL_W-1:0] numlines;
        logic [63:0]     cmd_time;
    } seq_cmd_t;

    function automatic logic addr_hit(input logic [7:0] addr, input int base, input logic [7:0] ofs);
        return addr == (8'(base) + ofs);
    endfunction

endpackage

// File: rtl/rx_run_sequencer_if.sv
// rtl/rx_run_sequencer_if.sv - settings bus, DSP input, sample output and status signals of rx_run_sequencer
interface rx_run_sequencer_if;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [63:0] vita_time;
    logic        dsp_strobe;
    logic [31:0] dsp_sample;
    logic        out_ready;
    logic        run;
    logic        out_stb;
    logic [31:0] out_sample;
    logic        out_eob;
    logic        status_stb;
    logic [2:0]  status;
    logic        busy;

    modport slave (
        input  set_stb, set_addr, set_data, vita_time, dsp_strobe, dsp_sample, out_ready,
        output run, out_stb, out_sample, out_eob, status_stb, status, busy
    );

    modport master (
        output set_stb, set_addr, set_data, vita_time, dsp_strobe, dsp_sample, out_ready,
        input  run, out_stb, out_sample, out_eob, status_stb, status, busy
    );
endinterface

// File: rtl/rx_run_sequencer_cmd_queue.sv
// rtl/rx_run_sequencer_cmd_queue.sv - up to two-entry command FIFO; entry 0 is the active command
module rx_run_sequencer_cmd_queue
    import rx_run_sequencer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  seq_cmd_t   push_cmd,
    output seq_cmd_t   head,
    output seq_cmd_t   next,
    output logic [1:0] level,
    output logic       full
);

    seq_cmd_t   e0;
    seq_cmd_t   e1;
    logic [1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 2'd0;
            e0  <= '0;
            e1  <= '0;
        end else if (flush) begin
            cnt <= 2'd0;
        end else if (push && pop) begin
            // Level is unchanged; the new command lands behind whatever survives the pop
            if (cnt == 2'd2) begin
                e0 <= e1;
                e1 <= push_cmd;
            end else begin
                e0 <= push_cmd;
            end
        end else if (pop) begin
            e0  <= e1;
            cnt <= cnt - 2'd1;
        end else if (push) begin
            if (cnt == 2'd0) begin
                e0 <= push_cmd;
            end else begin
                e1 <= push_cmd;
            end
            cnt <= cnt + 2'd1;
        end
    end

    assign head  = e0;
    assign next  = e1;
    assign level = cnt;
    assign full  = (cnt == 2'(DEPTH));

endmodule

// File: rtl/rx_run_sequencer.sv
// rtl/rx_run_sequencer.sv - timed RX stream controller; RX_SEQ_CHAIN_EN enables the two-deep chained command queue
module rx_run_sequencer
    import rx_run_sequencer_pkg::*;
#(
    parameter int BASE  = 160,
    parameter int CNT_W = 28
) (
    input logic              clk,
    input logic              rst,
    rx_run_sequencer_if.slave bus
);

`ifdef RX_SEQ_CHAIN_EN
    localparam int   QDEPTH   = 2;
    localparam logic CHAIN_OK = 1'b1;
`else
    localparam int   QDEPTH   = 1;
    localparam logic CHAIN_OK = 1'b0;
`endif

    logic             stg_now;
    logic             stg_chain;
    logic             stg_stop;
    logic [CNT_W-1:0] stg_lines;
    logic [31:0]      stg_time_hi;
    logic             commit_v;
    logic             commit_stop;
    logic             clear_v;
    seq_cmd_t         commit_cmd;

    // The time-low write commits; the FSM sees the command one cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_now     <= 1'b0;
            stg_chain   <= 1'b0;
            stg_stop    <= 1'b0;
            stg_lines   <= '0;
            stg_time_hi <= '0;
            commit_v    <= 1'b0;
            commit_stop <= 1'b0;
            clear_v     <= 1'b0;
            commit_cmd  <= '0;
        end else begin
            commit_v <= 1'b0;
            clear_v  <= 1'b0;
            if (bus.set_stb) begin
                if (addr_hit(bus.set_addr, BASE, OFS_CTRL)) begin
                    stg_now   <= bus.set_data[BIT_NOW];
                    stg_chain <= bus.set_data[BIT_CHAIN];
                    stg_stop  <= bus.set_data[BIT_STOP];
                    stg_lines <= bus.set_data[CNT_W-1:0];
                end
                if (addr_hit(bus.set_addr, BASE, OFS_TIME_HI)) begin
                    stg_time_hi <= bus.set_data;
                end
                if (addr_hit(bus.set_addr, BASE, OFS_TIME_LO)) begin
                    commit_v            <= 1'b1;
                    commit_stop         <= stg_stop;
                    commit_cmd.now      <= stg_now;
                    commit_cmd.chain    <= stg_chain & CHAIN_OK;
                    commit_cmd.numlines <= NL_W'(stg_lines);
                    commit_cmd.cmd_time <= {stg_time_hi, bus.set_data};
                end
                if (addr_hit(bus.set_addr, BASE, OFS_CLEAR)) begin
                    clear_v <= 1'b1;
                end
            end
        end
    end

    seq_state_t  state;
    seq_state_t  state_n;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_n;
    logic        q_push;
    logic        q_pop;
    logic        q_flush;
    logic        q_full;
    logic [1:0]  q_level;
    seq_cmd_t    q_head;
    seq_cmd_t    q_next;
    logic        stat_v;
    seq_status_t stat_code;

    rx_run_sequencer_cmd_queue #(.DEPTH(QDEPTH)) u_cmd_queue (
        .clk      (clk),
        .rst      (rst),
        .push     (q_push),
        .pop      (q_pop),
        .flush    (q_flush),
        .push_cmd (commit_cmd),
        .head     (q_head),
        .next     (q_next),
        .level    (q_level),
        .full     (q_full)
    );

    logic accept;
    logic overrun;
    logic last;
    logic stop_commit;
    logic cmd_commit;
    logic unused_q_fields;

    assign accept      = (state == ST_RUNNING) && bus.dsp_strobe && bus.out_ready;
    assign overrun     = (state == ST_RUNNING) && bus.dsp_strobe && !bus.out_ready;
    assign last        = accept && (count == CNT_W'(1));
    assign stop_commit = commit_v && commit_stop;
    assign cmd_commit  = commit_v && !commit_stop;
    assign unused_q_fields = ^{q_head.now, q_next.chain, q_next.cmd_time};

    always_comb begin
        state_n   = state;
        count_n   = count;
        q_push    = 1'b0;
        q_pop     = 1'b0;
        q_flush   = 1'b0;
        stat_v    = 1'b0;
        stat_code = STAT_NONE;
        case (state)
            ST_IDLE: begin
                if (cmd_commit) begin
                    q_push  = 1'b1;
                    count_n = commit_cmd.numlines[CNT_W-1:0];
                    state_n = commit_cmd.now ? ST_RUNNING : ST_WAIT_TIME;
                end
            end
            ST_WAIT_TIME: begin
                if (stop_commit) begin
                    q_flush = 1'b1;
                    state_n = ST_IDLE;
                end else if (bus.vita_time == q_head.cmd_time) begin
                    state_n = ST_RUNNING;
                end else if (bus.vita_time > q_head.cmd_time) begin
                    q_flush   = 1'b1;
                    state_n   = ST_ERR_HALT;
                    stat_v    = 1'b1;
                    stat_code = STAT_LATE;
                end
            end
            ST_RUNNING: begin
                if (stop_commit) begin
                    q_flush   = 1'b1;
                    count_n   = '0;
                    state_n   = ST_IDLE;
                    stat_v    = 1'b1;
                    stat_code = STAT_DONE;
                end else if (overrun) begin
                    q_flush   = 1'b1;
                    state_n   = ST_ERR_HALT;
                    stat_v    = 1'b1;
                    stat_code = STAT_OVERRUN;
                end else if (last) begin
                    // Hand straight over to a queued chained command without dropping run
                    if (q_head.chain && q_level == 2'd2) begin
                        q_pop   = 1'b1;
                        count_n = q_next.numlines[CNT_W-1:0];
                        state_n = q_next.now ? ST_RUNNING : ST_WAIT_TIME;
                    end else begin
                        q_flush   = 1'b1;
                        count_n   = '0;
                        state_n   = ST_IDLE;
                        stat_v    = 1'b1;
                        stat_code = STAT_DONE;
                    end
                end else if (accept && count != '0) begin
                    count_n = count - CNT_W'(1);
                end
            end
            ST_ERR_HALT: begin
                if (clear_v) begin
                    q_flush = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Commits outside IDLE queue up if there is room, else they bounce as BUSY.
        // A terminal status on the same cycle takes the status slot; the command is still dropped.
        if (commit_v && state != ST_IDLE &&
            !(commit_stop && (state == ST_WAIT_TIME || state == ST_RUNNING))) begin
            if (cmd_commit && state != ST_ERR_HALT && !q_flush && (!q_full || q_pop)) begin
                q_push = 1'b1;
            end else if (!stat_v) begin
                stat_v    = 1'b1;
                stat_code = STAT_BUSY;
            end
        end
    end

    logic        run_r;
    logic        busy_r;
    logic        out_stb_r;
    logic        out_eob_r;
    logic [31:0] out_sample_r;
    logic        status_stb_r;
    seq_status_t status_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            count        <= '0;
            run_r        <= 1'b0;
            busy_r       <= 1'b0;
            out_stb_r    <= 1'b0;
            out_eob_r    <= 1'b0;
            out_sample_r <= '0;
            status_stb_r <= 1'b0;
            status_r     <= STAT_NONE;
        end else begin
            state        <= state_n;
            count        <= count_n;
            run_r        <= (state_n == ST_RUNNING);
            busy_r       <= (state_n != ST_IDLE);
            out_stb_r    <= accept;
            out_eob_r    <= last;
            status_stb_r <= stat_v;
            if (accept) begin
                out_sample_r <= bus.dsp_sample;
            end
            if (stat_v) begin
                status_r <= stat_code;
            end
        end
    end

    assign bus.run        = run_r;
    assign bus.busy       = busy_r;
    assign bus.out_stb    = out_stb_r;
    assign bus.out_eob    = out_eob_r;
    assign bus.out_sample = out_sample_r;
    assign bus.status_stb = status_stb_r;
    assign bus.status     = status_r;

endmodule

// File: tb/tb_rx_run_sequencer.sv
// tb/tb_rx_run_sequencer.sv - randomized self-checking bench for rx_run_sequencer against a burst-level model
module tb_rx_run_sequencer;

    localparam int BASE = 160;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rx_run_sequencer_if bus();

    rx_run_sequencer #(.BASE(BASE), .CNT_W(28)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [32:0] got_samp[$];
    logic [32:0] exp_samp[$];
    int          got_stat[$];
    int          exp_stat[$];
    logic [31:0] sent[$];
    int          rises, falls, exp_rises, exp_falls;
    logic [63:0] rise_vita;
    logic        run_prev = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        if (!rst) begin
            if (bus.out_stb) got_samp.push_back({bus.out_eob, bus.out_sample});
            if (bus.status_stb) got_stat.push_back(int'(bus.status));
            if (bus.run && !run_prev) begin
                rises++;
                rise_vita = bus.vita_time;
            end
            if (!bus.run && run_prev) falls++;
        end
        run_prev = bus.run;
    end

    task automatic cyc();
        @(negedge clk);
        bus.vita_time  = bus.vita_time + 64'd1;
        bus.set_stb    = 1'b0;
        bus.dsp_strobe = 1'b0;
        bus.out_ready  = 1'b1;
    endtask

    task automatic settle(input int n);
        repeat (n) cyc();
    endtask

    task automatic write_reg(input int ofs, input logic [31:0] data);
        cyc();
        bus.set_stb  = 1'b1;
        bus.set_addr = 8'(BASE + ofs);
        bus.set_data = data;
    endtask

    task automatic commit(input bit now, input bit chain, input bit stop, input int lines, input logic [63:0] t);
        write_reg(0, {now, chain, stop, 1'b0, 28'(lines)});
        write_reg(1, t[63:32]);
        write_reg(2, t[31:0]);
    endtask

    task automatic wait_run(input string tag);
        int k = 0;
        while (!bus.run && k < 200) begin
            cyc();
            k++;
        end
        check_val({tag, "_run_up"}, 64'(bus.run), 64'd1);
    endtask

    task automatic send_strobes(input int count, input int drop);
        for (int k = 0; k < count; k++) begin
            repeat ($urandom_range(0, 2)) cyc();
            cyc();
            bus.dsp_strobe = 1'b1;
            bus.dsp_sample = $urandom;
            bus.out_ready  = (k != drop);
            sent.push_back(bus.dsp_sample);
        end
    endtask

    // Bursts of s0 then s1 lines taken back to back from the strobed samples
    task automatic expect_segments(input int s0, input int s1);
        for (int i = 0; i < s0 + s1 && i < sent.size(); i++) begin
            exp_samp.push_back({(i == s0 - 1) || (s1 > 0 && i == s0 + s1 - 1), sent[i]});
        end
    endtask

    task automatic clear_results();
        got_samp.delete();
        exp_samp.delete();
        got_stat.delete();
        exp_stat.delete();
        sent.delete();
        rises = 0;
        falls = 0;
        exp_rises = 0;
        exp_falls = 0;
    endtask

    task automatic compare_all(input string tag);
        check_val({tag, "_nsamp"}, 64'(got_samp.size()), 64'(exp_samp.size()));
        for (int i = 0; i < exp_samp.size() && i < got_samp.size(); i++)
            check_val($sformatf("%s_samp%0d", tag, i), 64'(got_samp[i]), 64'(exp_samp[i]));
        check_val({tag, "_nstat"}, 64'(got_stat.size()), 64'(exp_stat.size()));
        for (int i = 0; i < exp_stat.size() && i < got_stat.size(); i++)
            check_val($sformatf("%s_stat%0d", tag, i), 64'(got_stat[i]), 64'(exp_stat[i]));
        check_val({tag, "_rises"}, 64'(rises), 64'(exp_rises));
        check_val({tag, "_falls"}, 64'(falls), 64'(exp_falls));
        check_val({tag, "_idle"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic run_scenario(input int kind, input bit edge_case);
        int n, m, j, d;
        logic [63:0] t;
        clear_results();
        case (kind)
            0: begin
                n = edge_case ? 1 : $urandom_range(1, 12);
                commit(1, 0, 0, n, 64'd0);
                wait_run("imm");
                send_strobes(n + $urandom_range(0, 3), -1);
                settle(4);
                expect_segments(n, 0);
                exp_stat.push_back(1);
                exp_rises = 1; exp_falls = 1;
                compare_all("imm");
            end
            1: begin
                n = $urandom_range(1, 8);
                if (edge_case) begin
                    bus.vita_time = 64'd985;
                    t = 64'd1000;
                end else begin
                    d = $urandom_range(6, 40);
                    t = bus.vita_time + 64'(d);
                end
                commit(0, 0, 0, n, t);
                wait_run("timed");
                check_val("timed_rise_time", rise_vita, t);
                send_strobes(n + 1, -1);
                settle(4);
                expect_segments(n, 0);
                exp_stat.push_back(1);
                exp_rises = 1; exp_falls = 1;
                compare_all("timed");
            end
            2: begin
                t = bus.vita_time - 64'($urandom_range(1, 50));
                commit(0, 0, 0, $urandom_range(1, 8), t);
                settle(4);
                check_val("late_halt_busy", 64'(bus.busy), 64'd1);
                commit(1, 0, 0, 3, 64'd0);
                settle(3);
                check_val("late_still_halted", 64'(bus.busy), 64'd1);
                write_reg(3, $urandom);
                settle(3);
                exp_stat.push_back(2);
                exp_stat.push_back(4);
                compare_all("late");
            end
            3: begin
                n = $urandom_range(3, 15);
                commit(1, 0, 0, 0, 64'd0);
                wait_run("cont");
                send_strobes(n, -1);
                settle(2);
                check_val("cont_run_held", 64'(bus.run), 64'd1);
                commit(0, 0, 1, 0, 64'd0);
                settle(4);
                foreach (sent[i]) exp_samp.push_back({1'b0, sent[i]});
                exp_stat.push_back(1);
                exp_rises = 1; exp_falls = 1;
                compare_all("cont");
            end
            4: begin
                n = $urandom_range(2, 12);
                j = edge_case ? n - 1 : $urandom_range(0, n - 1);
                commit(1, 0, 0, n, 64'd0);
                wait_run("ovr");
                send_strobes(n + 2, j);
                settle(3);
                check_val("ovr_halt_busy", 64'(bus.busy), 64'd1);
                write_reg(3, $urandom);
                settle(3);
                expect_segments(n, 0);
                while (exp_samp.size() > j) void'(exp_samp.pop_back());
                exp_stat.push_back(3);
                exp_rises = 1; exp_falls = 1;
                compare_all("ovr");
            end
            5: begin
                n = $urandom_range(2, 8);
                m = $urandom_range(2, 8);
                commit(1, 1, 0, n, 64'd0);
                wait_run("two");
                commit(1, 0, 0, m, 64'd0);
                send_strobes(n + m + 2, -1);
                settle(4);
`ifdef RX_SEQ_CHAIN_EN
                expect_segments(n, m);
`else
                expect_segments(n, 0);
                exp_stat.push_back(4);
`endif
                exp_stat.push_back(1);
                exp_rises = 1; exp_falls = 1;
                compare_all("two");
            end
            6: begin
                commit(1, 0, 0, 10, 64'd0);
                wait_run("rst");
                send_strobes(3, -1);
                cyc();
                rst = 1'b1;
                #1;
                check_val("rst_run", 64'(bus.run), 64'd0);
                check_val("rst_out_stb", 64'(bus.out_stb), 64'd0);
                check_val("rst_status_stb", 64'(bus.status_stb), 64'd0);
                check_val("rst_out_sample", 64'(bus.out_sample), 64'd0);
                cyc();
                cyc();
                rst = 1'b0;
                settle(2);
                clear_results();
                compare_all("rst");
            end
            default: begin
                commit(0, 0, 1, $urandom_range(1, 8), bus.vita_time + 64'd5);
                settle(4);
                compare_all("stop_idle");
            end
        endcase
    endtask

    initial begin
        bus.set_stb    = 1'b0;
        bus.set_addr   = 8'd0;
        bus.set_data   = 32'd0;
        bus.vita_time  = 64'd1000;
        bus.dsp_strobe = 1'b0;
        bus.dsp_sample = 32'd0;
        bus.out_ready  = 1'b1;
        rst = 1'b1;
        settle(3);
        rst = 1'b0;
        settle(2);
        check_val("reset_ctrl", 64'({bus.run, bus.out_stb, bus.out_eob, bus.status_stb, bus.busy}), 64'd0);
        check_val("reset_status", 64'(bus.status), 64'd0);
        check_val("reset_sample", 64'(bus.out_sample), 64'd0);
        for (int it = 0; it < 8; it++) run_scenario(it, 1'b1);
        for (int it = 0; it < 24; it++) run_scenario(int'($urandom_range(0, 7)), 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
